// File: rtl/tusca_tx_if.sv
// Request/handshake bundle between the TUSCA control unit, the TX arbiter and the serial transmitter.
// The arbiter takes the slave side; the control unit and transmitter together form the master side.
interface tusca_tx_if;
    logic        req_medida;
    logic [31:0] medida;
    logic        req_erro;
    logic        req_config;
    logic [7:0]  config_ack;
    logic        pronto_serial;
    logic        partida_serial;
    logic [7:0]  dados_serial;
    logic        pronto_medida;
    logic        pronto_erro;
    logic        pronto_config;
    logic        erro_timeout;
    logic        ocupado;
    logic [3:0]  db_estado;

    modport master (
        output req_medida, medida, req_erro, req_config, config_ack, pronto_serial,
        input  partida_serial, dados_serial, pronto_medida, pronto_erro, pronto_config,
               erro_timeout, ocupado, db_estado
    );

    modport slave (
        input  req_medida, medida, req_erro, req_config, config_ack, pronto_serial,
        output partida_serial, dados_serial, pronto_medida, pronto_erro, pronto_config,
               erro_timeout, ocupado, db_estado
    );
endinterface

// File: rtl/tusca_tx_arbiter.sv
// Shares the byte-wide serial TX between the medida, erro and config sources: latches one-cycle
// requests, grants by fixed priority (config > erro > medida) and sends each frame byte by byte.
module tusca_tx_arbiter #(
    parameter int TIMEOUT = 5_000_000
) (
    input  logic      clock,
    input  logic      reset,
    tusca_tx_if.slave bus
);
    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        OCIOSO = 4'd0,
        ENVIA  = 4'd1,
        ESPERA = 4'd2,
        FIM    = 4'd3,
        ABORTA = 4'd4
    } estado_t;

    typedef enum logic [1:0] {SRC_MED, SRC_ERR, SRC_CFG} src_t;

    estado_t         estado_q;
    src_t            src_q, src_d;
    logic            pend_med_q, pend_err_q, pend_cfg_q;
    logic [31:0]     hold_med_q;
    logic [7:0]      hold_cfg_q;
    logic [6:0][7:0] frm_q, frm_d;
    logic [2:0]      len_q, len_d, idx_q;
    logic [CW-1:0]   cnt_q;
    logic            partida_q, pm_q, pe_q, pc_q, et_q, ocup_q;
    logic [7:0]      dados_q;
    logic [7:0]      chk;

    assign chk = hold_med_q[31:24] + hold_med_q[23:16] + hold_med_q[15:8] + hold_med_q[7:0];

    // Frame the winning source would get if granted on this edge
    always_comb begin
        frm_d = '0;
        len_d = 3'd2;
        src_d = SRC_ERR;
        if (pend_cfg_q) begin
            src_d    = SRC_CFG;
            len_d    = 3'd3;
            frm_d[0] = 8'h43;
            frm_d[1] = hold_cfg_q;
            frm_d[2] = 8'h0A;
        end else if (pend_err_q) begin
            frm_d[0] = 8'h45;
            frm_d[1] = 8'h0A;
        end else begin
            src_d    = SRC_MED;
            len_d    = 3'd7;
            frm_d[0] = 8'h4D;
            frm_d[1] = hold_med_q[31:24];
            frm_d[2] = hold_med_q[23:16];
            frm_d[3] = hold_med_q[15:8];
            frm_d[4] = hold_med_q[7:0];
            frm_d[5] = chk;
            frm_d[6] = 8'h0A;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            src_q      <= SRC_MED;
            pend_med_q <= 1'b0;
            pend_err_q <= 1'b0;
            pend_cfg_q <= 1'b0;
            hold_med_q <= '0;
            hold_cfg_q <= '0;
            frm_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            partida_q  <= 1'b0;
            dados_q    <= '0;
            pm_q       <= 1'b0;
            pe_q       <= 1'b0;
            pc_q       <= 1'b0;
            et_q       <= 1'b0;
            ocup_q     <= 1'b0;
        end else begin
            partida_q <= 1'b0;
            pm_q      <= 1'b0;
            pe_q      <= 1'b0;
            pc_q      <= 1'b0;
            et_q      <= 1'b0;
            case (estado_q)
                OCIOSO: if (pend_med_q || pend_err_q || pend_cfg_q) begin
                    src_q     <= src_d;
                    frm_q     <= frm_d;
                    len_q     <= len_d;
                    idx_q     <= '0;
                    case (src_d)
                        SRC_CFG: pend_cfg_q <= 1'b0;
                        SRC_ERR: pend_err_q <= 1'b0;
                        default: pend_med_q <= 1'b0;
                    endcase
                    partida_q <= 1'b1;
                    dados_q   <= frm_d[0];
                    ocup_q    <= 1'b1;
                    estado_q  <= ENVIA;
                end
                ENVIA: begin
                    cnt_q    <= '0;
                    estado_q <= ESPERA;
                end
                ESPERA: begin
                    if (bus.pronto_serial) begin
                        if (idx_q == len_q - 3'd1) begin
                            pm_q     <= (src_q == SRC_MED);
                            pe_q     <= (src_q == SRC_ERR);
                            pc_q     <= (src_q == SRC_CFG);
                            estado_q <= FIM;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            partida_q <= 1'b1;
                            dados_q   <= frm_q[idx_q + 3'd1];
                            estado_q  <= ENVIA;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        et_q     <= 1'b1;
                        estado_q <= ABORTA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    ocup_q   <= 1'b0;
                    estado_q <= OCIOSO;
                end
            endcase
            // Placed after the grant so a request on the grant edge re-arms the source
            if (bus.req_medida) begin
                pend_med_q <= 1'b1;
                hold_med_q <= bus.medida;
            end
            if (bus.req_erro) pend_err_q <= 1'b1;
            if (bus.req_config) begin
                pend_cfg_q <= 1'b1;
                hold_cfg_q <= bus.config_ack;
            end
        end
    end

    assign bus.partida_serial = partida_q;
    assign bus.dados_serial   = dados_q;
    assign bus.pronto_medida  = pm_q;
    assign bus.pronto_erro    = pe_q;
    assign bus.pronto_config  = pc_q;
    assign bus.erro_timeout   = et_q;
    assign bus.ocupado        = ocup_q;
    assign bus.db_estado      = estado_q;
endmodule

// File: doc/tusca_tx_arbiter.md
Name: tusca_tx_arbiter

Overview:
Shares the single byte-wide serial transmitter between the three TUSCA message sources: measurement report, measurement error, and configuration acknowledgement. Each source raises a one-cycle request. The arbiter latches the requests and grants them by fixed priority. It then sequences the selected multi-byte frame one byte at a time over the partida/pronto handshake of the serial transmitter. It sits between the main control unit and the serial TX, and replaces direct control-unit drive of the transmitter.

Parameters:
TIMEOUT, 5_000_000, maximum clock cycles to wait for pronto_serial after each byte start before aborting the frame.

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high
req_medida  in  1  one-cycle pulse: send measurement frame
medida  in  32  {hum_int, hum_dec, temp_int, temp_dec}; sampled when req_medida=1
req_erro  in  1  one-cycle pulse: send measurement-error frame
req_config  in  1  one-cycle pulse: send configuration-ack frame
config_ack  in  8  ack code; sampled when req_config=1
pronto_serial  in  1  one-cycle pulse from TX: current byte finished
partida_serial  out  1  one-cycle pulse: start transmitting dados_serial
dados_serial  out  8  byte to transmit
pronto_medida  out  1  one-cycle pulse: measurement frame fully sent
pronto_erro  out  1  one-cycle pulse: error frame fully sent
pronto_config  out  1  one-cycle pulse: config frame fully sent
erro_timeout  out  1  one-cycle pulse: frame aborted on timeout
ocupado  out  1  high whenever state != OCIOSO
db_estado  out  4  current state code

Behaviour:
- Reset: state OCIOSO; all pending bits, holding registers, byte index and timeout counter cleared. All outputs 0, including dados_serial=0x00.
- Pending bits: a req_x pulse sets pend_x. medida and config_ack are copied into per-source holding registers on the same edge; the latest request overwrites the held value. Repeated requests while a source is already pending coalesce into one frame.
- Frames:
  - Medida: 0x4D, hum_int, hum_dec, temp_int, temp_dec, chk, 0x0A (7 bytes). chk = 8-bit sum of the four data bytes mod 256.
  - Erro: 0x45, 0x0A (2 bytes).
  - Config: 0x43, ack, 0x0A (3 bytes).
- Priority: config > erro > medida. Fixed, non-preemptive; a frame in progress always completes or aborts.
- States (db_estado): OCIOSO=0, ENVIA=1, ESPERA=2, FIM=3, ABORTA=4.
- OCIOSO:
  - If any pend bit is set: grant the highest-priority source, clear its pend bit, and load the frame buffer from its holding register. Set byte index=0 and go to ENVIA.
  - Otherwise stay in OCIOSO.
- ENVIA: partida_serial=1 for exactly this cycle; dados_serial=frame[index]; timeout counter cleared; go to ESPERA.
- ESPERA:
  - dados_serial stays stable; the counter increments each cycle.
  - pronto_serial=1 and index==len-1: go to FIM.
  - pronto_serial=1 and index<len-1: increment index and go to ENVIA.
  - Otherwise, counter==TIMEOUT-1: go to ABORTA.
  - pronto_serial takes precedence over timeout in the same cycle.
- FIM: pronto_<granted source>=1 for one cycle; go to OCIOSO.
- ABORTA: erro_timeout=1 for one cycle; the aborted request is dropped (not retried); go to OCIOSO.
- Latency: req high at edge N sets pend at N. Grant happens at edge N+1, and partida_serial is high during the cycle after edge N+1. Back-to-back frames have one OCIOSO cycle between FIM and the next ENVIA.
- Request on the grant edge for the same source: set wins, so pend stays 1 and a second frame follows. The frame being granted uses the holding value from before that edge.
- Requests arriving during any frame are latched and never lost.
- pronto_serial outside ESPERA is ignored.
- Asynchronous reset mid-frame aborts immediately: no pronto or erro pulse, all pending requests discarded.

Test Plan:
1. req_medida with medida=0x3C05_1903 -> partida_serial 7 times with bytes 4D 3C 05 19 03 5D 0A, each after pronto_serial; pronto_medida exactly once, one cycle after the 7th pronto_serial.
2. req_config (config_ack=0xA5) and req_medida in the same cycle -> frame 43 A5 0A, then pronto_config, then 4D... medida frame, then pronto_medida; ocupado high throughout except one OCIOSO cycle between frames.
3. TIMEOUT=16, req_erro, pronto_serial never returned -> partida once (0x45); erro_timeout pulse at 16 cycles after ENVIA; no pronto_erro; a later req_medida is still served normally.
4. During a medida frame: req_medida with 0x0101_0101, then req_medida with 0x0202_0202 -> exactly one more medida frame follows, carrying 02 02 02 02 chk=08.
5. medida=0xFFFF_FFFF -> chk byte 0xFC (wrap-around).
6. reset asserted during byte 3 of a medida frame while req_config is pending -> all outputs 0 and db_estado=0 immediately; no frame sent after reset release.
